// File: rtl/iic_master_rw.sv
// I2C master with TX/RX byte FIFOs: write sessions stream queued bytes to a latched
// address, read sessions fetch a latched byte count and NACK the final byte.
module iic_master_rw #(
  parameter int QUARTER_DIV = 125,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 8
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_enable,
  input  logic             in_rw,
  input  logic [6:0]       in_device_address,
  input  logic [CNT_W-1:0] in_read_count,
  input  logic             in_tx_push,
  input  logic [7:0]       in_tx_data,
  input  logic             in_rx_pop,
  output logic [7:0]       out_rx_data,
  output logic             out_tx_full,
  output logic             out_tx_empty,
  output logic             out_rx_full,
  output logic             out_rx_empty,
  output logic             out_busy,
  output logic             out_nack,
  output logic             out_tx_overflow,
  input  logic             in_iic_sda,
  output logic             out_iic_scl,
  output logic             out_iic_sda,
  output logic             out_iic_sda_oe
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int QW = $clog2(QUARTER_DIV);
  localparam logic [AW:0] PTR_ONE = 1;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_START    = 4'd1;
  localparam logic [3:0] S_ADDR     = 4'd2;
  localparam logic [3:0] S_ADDR_ACK = 4'd3;
  localparam logic [3:0] S_PENDING  = 4'd4;
  localparam logic [3:0] S_WR_BYTE  = 4'd5;
  localparam logic [3:0] S_WR_ACK   = 4'd6;
  localparam logic [3:0] S_RD_BYTE  = 4'd7;
  localparam logic [3:0] S_RD_ACK   = 4'd8;
  localparam logic [3:0] S_STOP     = 4'd9;
  localparam logic [3:0] S_DONE     = 4'd10;

  logic [3:0]       state;
  logic [QW-1:0]    qcnt;
  logic [1:0]       qtr;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             samp;
  logic             en_q;
  logic             rw_q;
  logic [6:0]       addr_q;
  logic [CNT_W-1:0] remaining;
  logic             nack;
  logic             tx_ovf;

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr, tx_rd;
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wr, rx_rd;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_pop, tx_push_ok, tx_flush, rx_push, rx_pop_ok;
  logic bus_state, q_end, bit_end, sample_pt, start_ok;

  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);

  assign bus_state = (state != S_IDLE) && (state != S_PENDING) && (state != S_DONE);
  assign q_end     = (qcnt == QW'(QUARTER_DIV - 1));
  assign bit_end   = bus_state && q_end && (qtr == 2'd3);
  assign sample_pt = bus_state && q_end && (qtr == 2'd2);
  assign start_ok  = (state == S_IDLE) && in_enable && !en_q;

  assign tx_pop     = (state == S_PENDING) && !rw_q && !tx_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign tx_push_ok = in_tx_push && (!tx_full || tx_pop);
  assign tx_flush   = bit_end && samp && ((state == S_ADDR_ACK) || (state == S_WR_ACK));
  assign rx_push    = (state == S_RD_BYTE) && bit_end && (bit_cnt == 3'd7);
  assign rx_pop_ok  = in_rx_pop && !rx_empty;

  // NOTE: FIFO storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge in_clk) begin
    if (tx_push_ok) tx_mem[tx_wr[AW-1:0]] <= in_tx_data;
    if (rx_push)    rx_mem[rx_wr[AW-1:0]] <= shift;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      tx_wr <= '0;
      tx_rd <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (tx_push_ok) tx_wr <= tx_wr + PTR_ONE;
      if (tx_flush)    tx_rd <= tx_wr;
      else if (tx_pop) tx_rd <= tx_rd + PTR_ONE;
      if (rx_push)   rx_wr <= rx_wr + PTR_ONE;
      if (rx_pop_ok) rx_rd <= rx_rd + PTR_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state     <= S_IDLE;
      qcnt      <= '0;
      qtr       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      samp      <= 1'b1;
      en_q      <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      remaining <= '0;
      nack      <= 1'b0;
      tx_ovf    <= 1'b0;
    end else begin
      en_q <= in_enable;

      if (bus_state) begin
        if (q_end) begin
          qcnt <= '0;
          qtr  <= qtr + 2'd1;
        end else begin
          qcnt <= qcnt + QW'(1);
        end
      end else begin
        qcnt <= '0;
        qtr  <= '0;
      end

      if (sample_pt) begin
        samp <= in_iic_sda;
        if (state == S_RD_BYTE) shift <= {shift[6:0], in_iic_sda};
      end

      if (start_ok) tx_ovf <= 1'b0;
      if (in_tx_push && tx_full && !tx_pop) tx_ovf <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start_ok) begin
            rw_q      <= in_rw;
            addr_q    <= in_device_address;
            remaining <= in_read_count;
            nack      <= 1'b0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            shift   <= {addr_q, rw_q};
            bit_cnt <= '0;
            state   <= S_ADDR;
          end
        end
        S_ADDR, S_WR_BYTE: begin
          if (bit_end) begin
            shift   <= {shift[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= (state == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
          end
        end
        S_ADDR_ACK, S_WR_ACK: begin
          if (bit_end) begin
            if (samp) begin
              nack  <= 1'b1;
              state <= S_STOP;
            end else begin
              state <= S_PENDING;
            end
          end
        end
        S_PENDING: begin
          bit_cnt <= '0;
          if (!rw_q) begin
            if (!tx_empty) begin
              shift <= tx_mem[tx_rd[AW-1:0]];
              state <= S_WR_BYTE;
            end else if (!in_enable) begin
              state <= S_STOP;
            end
          end else if (remaining == '0) begin
            state <= S_STOP;
          end else if (!rx_full) begin
            state <= S_RD_BYTE;
          end
        end
        S_RD_BYTE: begin
          if (bit_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_RD_ACK;
          end
        end
        S_RD_ACK: begin
          if (bit_end) begin
            remaining <= remaining - CNT_W'(1);
            state     <= S_PENDING;
          end
        end
        S_STOP:  if (bit_end) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus pins are decoded from registered state, so reset releases them immediately.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    out_iic_scl    = 1'b1;
    out_iic_sda_oe = 1'b0;
    case (state)
      S_START: out_iic_sda_oe = qtr[1];
      S_ADDR, S_WR_BYTE: begin
        out_iic_scl    = qtr[1];
        out_iic_sda_oe = ~shift[7];
      end
      S_ADDR_ACK, S_WR_ACK, S_RD_BYTE: out_iic_scl = qtr[1];
      S_RD_ACK: begin
        out_iic_scl    = qtr[1];
        out_iic_sda_oe = (remaining > CNT_W'(1));
      end
      S_PENDING: out_iic_scl = 1'b0;
      S_STOP: begin
        out_iic_scl    = (qtr != 2'd0);
        out_iic_sda_oe = (qtr != 2'd3);
      end
      default: ;
    endcase
  end

  assign out_iic_sda     = 1'b0;
  assign out_rx_data     = rx_empty ? 8'h00 : rx_mem[rx_rd[AW-1:0]];
  assign out_tx_full     = tx_full;
  assign out_tx_empty    = tx_empty;
  assign out_rx_full     = rx_full;
  assign out_rx_empty    = rx_empty;
  assign out_busy        = (state != S_IDLE);
  assign out_nack        = nack;
  assign out_tx_overflow = tx_ovf;

endmodule

// File: doc/iic_master_rw.md
Name: iic_master_rw

Overview:
Parametrised I2C master for byte streams in both directions. It contains its own bit engine, a TX FIFO and an RX FIFO. Write sessions stream TX FIFO bytes to a latched 7-bit address until the host drops enable. Read sessions fetch a latched byte count into the RX FIFO, ACK every byte except the last, NACK the last, and detect slave NACK with flush and STOP.

Parameters:
QUARTER_DIV, 125, in_clk cycles per quarter SCL bit period (100 kHz at 50 MHz); must be >=2.
FIFO_DEPTH, 16, entries in each of the TX and RX FIFOs; power of two, >=2.
CNT_W, 8, width of the read byte count.

Ports:
in_clk  input  1  clock
in_rst_n  input  1  asynchronous, active-low reset
in_enable  input  1  session request, level; its rising edge starts a session
in_rw  input  1  0 = write, 1 = read; sampled on the in_enable rising edge
in_device_address  input  7  sampled on the in_enable rising edge
in_read_count  input  CNT_W  bytes to read; sampled on the in_enable rising edge
in_tx_push  input  1  one-cycle push strobe
in_tx_data  input  8  byte to push
in_rx_pop  input  1  one-cycle pop strobe
out_rx_data  output  8  head of RX FIFO (show-ahead)
out_tx_full / out_tx_empty / out_rx_full / out_rx_empty  output  1 each  FIFO flags
out_busy  output  1  high whenever the FSM is not in IDLE
out_nack  output  1  sticky: slave NACKed
out_tx_overflow  output  1  sticky: a push was dropped
in_iic_sda  input  1  SDA line value
out_iic_scl  output  1  SCL, push-pull (no clock stretching support)
out_iic_sda  output  1  SDA drive value, always 0 when driven
out_iic_sda_oe  output  1  1 = drive SDA low, 0 = release SDA

Behaviour:
- Reset (asynchronous, in_rst_n=0), effective immediately:
  - out_iic_scl=1, out_iic_sda_oe=0, out_iic_sda=0.
  - out_busy=0, out_nack=0, out_tx_overflow=0.
  - Both FIFOs are emptied: empty flags=1, full flags=0, out_rx_data=0.
  - FSM goes to IDLE.
  - Reset mid-byte releases the bus without a STOP. Bus recovery is out of scope.
- Edge detect: in_enable is registered once. A rising edge seen in IDLE:
  - latches in_rw, in_device_address and in_read_count;
  - clears out_nack and out_tx_overflow;
  - enters START on the next cycle.
  - Rising edges outside IDLE are ignored.
- Bit timing: every bus bit is 4 quarters of QUARTER_DIV clocks each.
  - q0: SCL low; SDA is updated at the start of q0.
  - q1: SCL low.
  - q2: SCL high; SDA is sampled on the last clock of q2.
  - q3: SCL high.
- START: SDA released and SCL high for q0–q1. SDA driven low at q2 with SCL still high. SCL low after q3.
- STOP: SDA low with SCL low (q0). SCL high from q1. SDA released at q3.
- FSM states: IDLE, START, ADDR (8 bits: {addr, in_rw}), ADDR_ACK, PENDING, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP, DONE.
  - IDLE -> START on an accepted rising edge.
  - START -> ADDR.
  - ADDR -> ADDR_ACK.
  - ADDR_ACK: if sampled SDA=1, set out_nack and go to STOP. Otherwise go to PENDING.
  - PENDING, write mode:
    - TX FIFO not empty -> WR_BYTE. The head is popped on entry and shifted out MSB first.
    - TX FIFO empty and in_enable=0 -> STOP.
    - Otherwise stay in PENDING with SCL held low.
  - WR_ACK: sampled 1 -> set out_nack, flush the TX FIFO, go to STOP. Sampled 0 -> PENDING.
  - PENDING, read mode:
    - remaining=0 -> STOP.
    - RX FIFO full -> stay, with SCL held low.
    - Otherwise -> RD_BYTE. SDA is released and 8 bits are sampled, MSB first.
  - RD_ACK: the byte is written into the RX FIFO on entry. SDA is driven low (ACK) if remaining>1, else released (NACK). remaining is decremented, then go to PENDING.
  - A read_count of 0 produces address + STOP only.
  - STOP -> DONE -> IDLE. DONE lasts one cycle.
- FIFOs: synchronous. Push and pop take effect on the clock edge.
  - A push while full is dropped and sets out_tx_overflow, unless a pop happens in the same cycle, in which case the push is accepted.
  - A pop while empty is ignored.
  - The RX FIFO is written only by the FSM. The full check in PENDING guarantees it never overflows.
- Pushes are accepted at any time, including in IDLE and in read mode. Bytes stay queued for the next write session.

Test Plan:
- Write 2 bytes: in_enable↑, rw=0, addr=0x50; push 0xA5, 0x3C; drop enable -> bus shows START, 0xA0, ACK, 0xA5, ACK, 0x3C, ACK, STOP; out_busy falls; out_tx_empty=1.
- Read 3 bytes: rw=1, addr=0x48, count=3; slave returns 0x11, 0x22, 0x33 -> bus shows 0x91 then master ACK, ACK, NACK, STOP; pops give 0x11, 0x22, 0x33.
- Address NACK: slave leaves SDA high at ADDR_ACK -> out_nack=1, STOP, TX FIFO flushed; the next in_enable↑ clears out_nack.
- RX back-pressure: FIFO_DEPTH=4, count=6, no pops -> SCL held low after the 4th byte with out_rx_full=1; one pop resumes the transfer; all 6 bytes arrive in order.
- TX overflow: push 17 bytes with FIFO_DEPTH=16 while idle -> out_tx_overflow=1, out_tx_full=1; a push and pop in the same cycle while full raises no overflow.
- Async reset mid-byte in WR_BYTE -> SCL=1 and SDA_oe=0 in the same cycle; all flags return to their reset values.
